flux_histogram_bram: RTL
========================

FLUX_HISTOGRAM_BRAM -- requirements
Module: flux_histogram_bram

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, meaning number of independent histograms sharing one RAM.
REQ-002 SHALL have parameter BIN_BITS, default 8, meaning log2 bins per channel (BIN_COUNT = 2**BIN_BITS).
REQ-003 SHALL have parameter BIN_WIDTH, default 16, meaning saturating counter width per bin.
REQ-004 SHALL have parameter INTERVAL_BITS, default 16, meaning flux interval width.
REQ-005 SHALL have ports: clk input 1 system clock; reset input 1 synchronous active-high reset; one clock domain only.
REQ-006 SHALL have ports: flux_valid input 1 transition strobe; flux_interval input INTERVAL_BITS clocks since last transition; flux_ch input CHW = max(1,clog2(NUM_CH)) target channel.
REQ-007 SHALL have ports: enable input 1 collect gate; clear input 1 pulse starting RAM/stat sweep; bin_shift input 4 right-shift; bin_offset input INTERVAL_BITS lowest binned interval; window_limit input 32 auto-stop count (0 = unlimited).
REQ-008 SHALL have ports: rd_en input 1; rd_ch input CHW; rd_bin input BIN_BITS; rd_data output BIN_WIDTH; rd_valid output 1.
REQ-009 SHALL have ports: busy output 1 clear sweep active; done output 1 window reached; dropped_count output 32 strobes ignored while busy/done.
REQ-010 SHALL have per-channel outputs flattened, channel 0 in LSBs: total_count NUM_CH*32, underflow_count NUM_CH*32, overflow_count NUM_CH*32, peak_bin NUM_CH*BIN_BITS, peak_count NUM_CH*BIN_WIDTH.

Function
REQ-011 SHALL implement FSM states CLEAR, RUN, DONE; CLEAR entered on reset or clear, RUN after sweep, DONE when window reached.
REQ-012 CLEAR SHALL write zero to one RAM word per cycle, address 0 to NUM_CH*BIN_COUNT-1, busy=1 throughout, then go RUN; clear asserted during CLEAR restarts sweep at 0.
REQ-013 CLEAR entry SHALL zero all counters, peak_bin, peak_count, done; dropped_count cleared by reset only.
REQ-014 In RUN, accepted strobe = flux_valid & enable & (flux_ch < NUM_CH); flux_ch >= NUM_CH ignored, not counted.
REQ-015 Stage S0: d = flux_interval - bin_offset; interval < bin_offset -> underflow_count[ch]+1, no bin update; else idx = d >> bin_shift, clamped to BIN_COUNT-1 with overflow_count[ch]+1 when idx >= BIN_COUNT.
REQ-016 Pipeline SHALL be S0 address, S1 RAM read, S2 increment/write at {ch,idx}; bin write 2 cycles after strobe; one strobe accepted per cycle, no backpressure.
REQ-017 Back-to-back strobes to same {ch,idx} SHALL forward S2 write value into S1 so every strobe counts (N strobes -> +N).
REQ-018 Bin increment SHALL saturate at all-ones; saturated bins hold and do not change peak.
REQ-019 In S2, new count > peak_count[ch] SHALL set peak_count[ch]=new count, peak_bin[ch]=idx; ties keep earlier bin.
REQ-020 total_count[ch] SHALL increment on every accepted strobe incl. under/overflow, wrapping at 2**32.
REQ-021 window_limit != 0 and sum of all total_count reaching window_limit SHALL enter DONE next cycle, done=1; in-flight pipeline ops still complete.
REQ-022 Strobes during CLEAR or DONE SHALL increment dropped_count (saturating); DONE exits only via clear or reset.
REQ-023 Read port SHALL be independent RAM port: rd_data, rd_valid=1 one cycle after rd_en, else rd_valid=0; same-cycle write to same word returns old value.
REQ-024 clear coincident with flux_valid: clear wins, strobe dropped and counted in dropped_count.
REQ-025 bin_shift, bin_offset sampled in S0 per strobe; changes mid-run SHALL not corrupt in-flight ops.

Reset
REQ-026 reset SHALL force CLEAR at address 0; all outputs 0 (rd_data, rd_valid, busy set 1 next cycle); RAM contents valid only after sweep.
REQ-027 reset mid-pipeline SHALL cancel S1/S2 writes; reset mid-sweep SHALL restart sweep.

Structure
REQ-028 Shared package SHALL hold FSM state encoding and CHW/RAM-depth helper functions.
REQ-029 Sub-module flux_hist_ram SHALL be simple dual-port RAM (write port + registered read port, read-first), inferable as block RAM.

Verification
REQ-030 Reset, NUM_CH=2, BIN_BITS=8 -> busy high 512 cycles, then RUN; read any bin -> 0.
REQ-031 shift=2, offset=0, ch0, 10 consecutive-cycle strobes interval 40 -> bin 10 = 10, peak_bin[0]=10, peak_count[0]=10, total_count[0]=10.
REQ-032 offset=16: interval 8 -> underflow_count=1; interval 16+4*300 -> overflow_count=1, bin 255 = 1.
REQ-033 BIN_WIDTH=4, 20 strobes to one bin -> bin = 15, peak_count = 15.
REQ-034 window_limit=5, 8 strobes ch1 -> done=1, total_count[1]=5, dropped_count=3.
REQ-035 clear pulse same cycle as strobe, then 1 strobe during sweep -> dropped_count=2, all bins 0 after sweep.

Source files
------------

// File: rtl/flux_histogram_bram_pkg.sv
// Shared definitions for the flux-interval histogram: FSM encoding and sizing helpers.
package flux_histogram_bram_pkg;

   typedef enum logic [1:0] {
      ST_CLEAR = 2'd0,
      ST_RUN   = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   // Channel-select width; a single channel still gets one select bit.
   function automatic int ch_width(input int num_ch);
      return (num_ch > 1) ? $clog2(num_ch) : 1;
   endfunction

   // Number of RAM words actually used (and swept on clear).
   function automatic int ram_depth(input int num_ch, input int bin_bits);
      return num_ch << bin_bits;
   endfunction

endpackage

// File: rtl/flux_histogram_bram_if.sv
// Strobe input and bin read-back bus of the flux histogram.
interface flux_histogram_bram_if #(
   parameter int NUM_CH        = 2,
   parameter int BIN_BITS      = 8,
   parameter int BIN_WIDTH     = 16,
   parameter int INTERVAL_BITS = 16
);
   import flux_histogram_bram_pkg::*;

   localparam int CHW = ch_width(NUM_CH);

   logic                     flux_valid;
   logic [INTERVAL_BITS-1:0] flux_interval;
   logic [CHW-1:0]           flux_ch;
   logic                     rd_en;
   logic [CHW-1:0]           rd_ch;
   logic [BIN_BITS-1:0]      rd_bin;
   logic [BIN_WIDTH-1:0]     rd_data;
   logic                     rd_valid;

   modport master (
      output flux_valid, flux_interval, flux_ch, rd_en, rd_ch, rd_bin,
      input  rd_data, rd_valid
   );

   modport slave (
      input  flux_valid, flux_interval, flux_ch, rd_en, rd_ch, rd_bin,
      output rd_data, rd_valid
   );

endinterface

// File: rtl/flux_hist_ram.sv
// Simple dual-port RAM: one write port, one registered read-first read port.
module flux_hist_ram #(
   parameter int AW = 9,
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [2**AW];

   // Write port.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   // Registered read; a same-edge write to the same word returns the old data.
   always_ff @(posedge clk) begin
      if (reset)   rdata <= '0;
      else if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/flux_histogram_bram.sv
// Multi-channel flux-interval histogram in block RAM with saturating bins,
// per-channel stats, peak tracking, window auto-stop and a swept clear.
module flux_histogram_bram #(
   parameter int NUM_CH        = 2,
   parameter int BIN_BITS      = 8,
   parameter int BIN_WIDTH     = 16,
   parameter int INTERVAL_BITS = 16
) (
   input  logic                          clk,
   input  logic                          reset,
   flux_histogram_bram_if.slave          bus,
   input  logic                          enable,
   input  logic                          clear,
   input  logic [3:0]                    bin_shift,
   input  logic [INTERVAL_BITS-1:0]      bin_offset,
   input  logic [31:0]                   window_limit,
   output logic                          busy,
   output logic                          done,
   output logic [31:0]                   dropped_count,
   output logic [NUM_CH*32-1:0]          total_count,
   output logic [NUM_CH*32-1:0]          underflow_count,
   output logic [NUM_CH*32-1:0]          overflow_count,
   output logic [NUM_CH*BIN_BITS-1:0]    peak_bin,
   output logic [NUM_CH*BIN_WIDTH-1:0]   peak_count
);
   import flux_histogram_bram_pkg::*;

   localparam int CHW   = ch_width(NUM_CH);
   localparam int AW    = CHW + BIN_BITS;
   localparam int DEPTH = ram_depth(NUM_CH, BIN_BITS);
   // One bit per encodable channel number, set for channels that exist.
   localparam logic [(1<<CHW)-1:0] CH_MASK = {(1<<CHW){1'b1}} >> ((1<<CHW) - NUM_CH);

   typedef struct packed {
      logic [CHW-1:0]      ch;
      logic [BIN_BITS-1:0] idx;
   } op_t;

   state_t                           state_q, state_d;
   logic [AW-1:0]                    sweep_q, sweep_d;
   logic [NUM_CH-1:0][31:0]          tot_q, und_q, ovf_q;
   logic [NUM_CH-1:0][BIN_BITS-1:0]  pk_bin_q;
   logic [NUM_CH-1:0][BIN_WIDTH-1:0] pk_cnt_q;
   logic [31:0]                      drop_q, tot_sum;
   logic [INTERVAL_BITS-1:0]         s0_diff, s0_shifted;
   logic                             s0_under, s0_over, s0_acc, s0_drop, s0_upd, win_hit;
   op_t                              s0_op, s1_q, s2_q, wb_q;
   logic [2:1]                       vld_pipe;
   logic                             wb_vld_q, s1_sat, s2_sat_q;
   logic [BIN_WIDTH-1:0]             ram_q, s1_cur, s1_cnt, s2_cnt_q, wb_cnt_q;
   logic                             ram_we;
   logic [AW-1:0]                    ram_waddr;
   logic [BIN_WIDTH-1:0]             ram_wdata;

   // Sum of all channel totals for the window stop.
   always_comb begin
      tot_sum = '0;
      for (int c = 0; c < NUM_CH; c++) tot_sum += tot_q[c];
   end

   // S0: accept/drop decision and bin index from the strobe's interval.
   always_comb begin
      win_hit    = (window_limit != '0) && (tot_sum >= window_limit);
      s0_acc     = (state_q == ST_RUN) && !clear && !win_hit && bus.flux_valid &&
                   enable && CH_MASK[bus.flux_ch];
      s0_drop    = bus.flux_valid && (clear || win_hit || state_q != ST_RUN);
      s0_under   = bus.flux_interval < bin_offset;
      s0_diff    = bus.flux_interval - bin_offset;
      s0_shifted = s0_diff >> bin_shift;
      s0_over    = (s0_shifted >> BIN_BITS) != '0;
      s0_op.ch   = bus.flux_ch;
      s0_op.idx  = s0_over ? '1 : s0_shifted[BIN_BITS-1:0];
      s0_upd     = s0_acc && !s0_under;
   end

   // FSM next state: sweep RAM in CLEAR, stop in DONE when the window fills.
   always_comb begin
      state_d = state_q;
      sweep_d = sweep_q;
      unique case (state_q)
         ST_CLEAR: begin
            sweep_d = sweep_q + 1'b1;
            if (sweep_q == AW'(DEPTH - 1)) begin
               state_d = ST_RUN;
               sweep_d = '0;
            end
         end
         ST_RUN:  if (win_hit) state_d = ST_DONE;
         ST_DONE: state_d = ST_DONE;
         default: state_d = ST_CLEAR;
      endcase
      if (clear) begin
         state_d = ST_CLEAR;
         sweep_d = '0;
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_CLEAR;
         sweep_q <= '0;
      end else begin
         state_q <= state_d;
         sweep_q <= sweep_d;
      end
   end

   // Per-channel strobe statistics, zeroed on every entry to CLEAR.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         tot_q <= '0;
         und_q <= '0;
         ovf_q <= '0;
      end else if (s0_acc) begin
         tot_q[bus.flux_ch] <= tot_q[bus.flux_ch] + 32'd1;
         if (s0_under)     und_q[bus.flux_ch] <= und_q[bus.flux_ch] + 32'd1;
         else if (s0_over) ovf_q[bus.flux_ch] <= ovf_q[bus.flux_ch] + 32'd1;
      end
   end

   // Dropped strobes saturate and survive clear.
   always_ff @(posedge clk) begin
      if (reset)                         drop_q <= '0;
      else if (s0_drop && drop_q != '1)  drop_q <= drop_q + 32'd1;
   end

   // S1: current bin value, forwarded from S2 (write this cycle) or the
   // previous write (which landed on the same edge as our read-first read).
   always_comb begin
      s1_cur = ram_q;
      if (vld_pipe[2] && s2_q == s1_q)  s1_cur = s2_cnt_q;
      else if (wb_vld_q && wb_q == s1_q) s1_cur = wb_cnt_q;
      s1_sat = &s1_cur;
      s1_cnt = s1_sat ? s1_cur : s1_cur + 1'b1;
   end

   // Pipeline valid shift register; reset and clear cancel in-flight writes.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         vld_pipe <= '0;
         wb_vld_q <= 1'b0;
      end else begin
         vld_pipe <= {vld_pipe[1], s0_upd};
         wb_vld_q <= vld_pipe[2];
      end
   end

   // Pipeline datapath registers.
   always_ff @(posedge clk) begin
      s1_q     <= s0_op;
      s2_q     <= s1_q;
      s2_cnt_q <= s1_cnt;
      s2_sat_q <= s1_sat;
      wb_q     <= s2_q;
      wb_cnt_q <= s2_cnt_q;
   end

   // S2 peak tracking; strict compare keeps the earlier bin on ties.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         pk_bin_q <= '0;
         pk_cnt_q <= '0;
      end else if (vld_pipe[2] && !s2_sat_q && s2_cnt_q > pk_cnt_q[s2_q.ch]) begin
         pk_cnt_q[s2_q.ch] <= s2_cnt_q;
         pk_bin_q[s2_q.ch] <= s2_q.idx;
      end
   end

   // RAM write port: zero sweep in CLEAR, otherwise the S2 increment.
   always_comb begin
      ram_waddr = s2_q;
      ram_wdata = s2_cnt_q;
      ram_we    = vld_pipe[2] && !reset && !clear;
      if (state_q == ST_CLEAR) begin
         ram_we    = !reset;
         ram_waddr = sweep_q;
         ram_wdata = '0;
      end
   end

   // Two copies share the write port so the update pipe and read-back never contend.
   flux_hist_ram #(.AW(AW), .DW(BIN_WIDTH)) u_ram_upd (
      .clk(clk), .reset(reset), .we(ram_we), .waddr(ram_waddr), .wdata(ram_wdata),
      .re(s0_upd), .raddr(s0_op), .rdata(ram_q)
   );

   flux_hist_ram #(.AW(AW), .DW(BIN_WIDTH)) u_ram_rd (
      .clk(clk), .reset(reset), .we(ram_we), .waddr(ram_waddr), .wdata(ram_wdata),
      .re(bus.rd_en), .raddr({bus.rd_ch, bus.rd_bin}), .rdata(bus.rd_data)
   );

   // Read-back valid follows rd_en by one cycle.
   always_ff @(posedge clk) begin
      if (reset) bus.rd_valid <= 1'b0;
      else       bus.rd_valid <= bus.rd_en;
   end

   assign busy            = (state_q == ST_CLEAR);
   assign done            = (state_q == ST_DONE);
   assign dropped_count   = drop_q;
   assign total_count     = tot_q;
   assign underflow_count = und_q;
   assign overflow_count  = ovf_q;
   assign peak_bin        = pk_bin_q;
   assign peak_count      = pk_cnt_q;

endmodule
